// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: request/response bundle between the four cache ports, the arbiter and the line memory.
//   port_req_valid/write/addr/wdata  cache -> arbiter request, flattened per port
//   port_req_ready                   arbiter -> cache one-hot grant
//   port_resp_valid/rdata            arbiter -> cache read-data pulse and shared line
//   mem_req_valid/write/addr/wdata   arbiter -> memory request
//   mem_req_ready                    memory -> arbiter accept
//   mem_resp_valid/rdata             memory -> arbiter read-data pulse and line
//   modport slave is the arbiter's view; modport master is the cache/memory side.
interface mem_req_arbiter_if #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int LINE_BYTES = 64,
   parameter int DATA_WIDTH = LINE_BYTES * 8
);
   logic [NUM_PORTS-1:0]            port_req_valid;
   logic [NUM_PORTS-1:0]            port_req_write;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] port_req_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] port_req_wdata;
   logic [NUM_PORTS-1:0]            port_req_ready;
   logic [NUM_PORTS-1:0]            port_resp_valid;
   logic [DATA_WIDTH-1:0]           port_resp_rdata;
   logic                            mem_req_valid;
   logic                            mem_req_write;
   logic [ADDR_WIDTH-1:0]           mem_req_addr;
   logic [DATA_WIDTH-1:0]           mem_req_wdata;
   logic                            mem_req_ready;
   logic                            mem_resp_valid;
   logic [DATA_WIDTH-1:0]           mem_resp_rdata;
   modport slave (
      input  port_req_valid, port_req_write, port_req_addr, port_req_wdata,
      output port_req_ready, port_resp_valid, port_resp_rdata,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata
   );
   modport master (
      output port_req_valid, port_req_write, port_req_addr, port_req_wdata,
      input  port_req_ready, port_resp_valid, port_resp_rdata,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin serializer of cache line requests onto the single memory port, one transaction in flight.
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   bus           mem_req_arbiter_if.slave: cache request/grant/response and memory request/response
//   protocol_err  sticky flag for a memory response arriving while no read is pending
module mem_req_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int LINE_BYTES = 64,
   parameter int DATA_WIDTH = LINE_BYTES * 8
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_req_arbiter_if.slave   bus,
   output logic               protocol_err
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
   state_t                state, state_nxt;
   logic [PW-1:0]         rr_ptr, owner, gidx;
   logic                  found;
   logic [NUM_PORTS-1:0]  grant;
   logic                  mem_req_valid, mem_req_write;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic [DATA_WIDTH-1:0] mem_req_wdata, port_resp_rdata;
   logic [NUM_PORTS-1:0]  port_resp_valid;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
   endfunction
   // first valid port searching upward from rr_ptr, wrapping modulo NUM_PORTS
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!found && bus.port_req_valid[PW'((int'(rr_ptr) + i) % NUM_PORTS)]) begin
            found = 1'b1;
            gidx  = PW'((int'(rr_ptr) + i) % NUM_PORTS);
         end
      end
      grant = found ? NUM_PORTS'(1) << gidx : '0;
   end
   // the grant is combinational, so it is masked while reset is held
   assign bus.port_req_ready  = (state == IDLE) ? grant & {NUM_PORTS{rst_n}} : '0;
   assign bus.port_resp_valid = port_resp_valid;
   assign bus.port_resp_rdata = port_resp_rdata;
   assign bus.mem_req_valid   = mem_req_valid;
   assign bus.mem_req_write   = mem_req_write;
   assign bus.mem_req_addr    = mem_req_addr;
   assign bus.mem_req_wdata   = mem_req_wdata;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = found ? ISSUE : IDLE;
         ISSUE:     state_nxt = bus.mem_req_ready ? (mem_req_write ? IDLE : WAIT_RESP) : ISSUE;
         WAIT_RESP: state_nxt = bus.mem_resp_valid ? IDLE : WAIT_RESP;
         default:   state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr          <= '0;
         owner           <= '0;
         mem_req_valid   <= 1'b0;
         mem_req_write   <= 1'b0;
         mem_req_addr    <= '0;
         mem_req_wdata   <= '0;
         port_resp_valid <= '0;
         port_resp_rdata <= '0;
         protocol_err    <= 1'b0;
      end else begin
         port_resp_valid <= '0;
         protocol_err    <= protocol_err | (bus.mem_resp_valid && state != WAIT_RESP);
         case (state)
            IDLE: if (found) begin
               owner         <= gidx;
               mem_req_valid <= 1'b1;
               mem_req_write <= bus.port_req_write[gidx];
               mem_req_addr  <= bus.port_req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
               mem_req_wdata <= bus.port_req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            end
            ISSUE: if (bus.mem_req_ready) begin
               mem_req_valid <= 1'b0;
               if (mem_req_write) rr_ptr <= nxt(owner);
            end
            WAIT_RESP: if (bus.mem_resp_valid) begin
               port_resp_valid <= NUM_PORTS'(1) << owner;
               port_resp_rdata <= bus.mem_resp_rdata;
               rr_ptr          <= nxt(owner);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits directly upstream of the shared 8 MB line memory.
- Collects line read and write requests from the four cache controllers (NUM_PORTS ports) and serializes them onto the memory's single request port using fair round-robin arbitration.
- Routes each read response back to the port that issued the read.
- Allows only one memory transaction in flight at a time, because the memory's ready is low while a read is pending.

Parameters:
- NUM_PORTS, 4, number of requesting cache ports.
- ADDR_WIDTH, 64, byte address width.
- LINE_BYTES, 64, bytes per line.
- DATA_WIDTH, LINE_BYTES*8, line data width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- port_req_valid  in  NUM_PORTS  per-port request valid.
- port_req_write  in  NUM_PORTS  per-port 1=write, 0=read.
- port_req_addr  in  NUM_PORTS*ADDR_WIDTH  flattened; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- port_req_wdata  in  NUM_PORTS*DATA_WIDTH  flattened; port p at [p*DATA_WIDTH +: DATA_WIDTH].
- port_req_ready  out  NUM_PORTS  one-hot grant; the request is accepted on the edge where valid&ready.
- port_resp_valid  out  NUM_PORTS  one-cycle read-data pulse, one-hot.
- port_resp_rdata  out  DATA_WIDTH  read line, shared by all ports; qualified by port_resp_valid.
- mem_req_valid  out  1  request to memory.
- mem_req_write  out  1  request type to memory.
- mem_req_addr  out  ADDR_WIDTH  request address to memory.
- mem_req_wdata  out  DATA_WIDTH  write line to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  memory read-data pulse.
- mem_resp_rdata  in  DATA_WIDTH  memory read line.
- protocol_err  out  1  sticky; set on a mem_resp_valid outside WAIT_RESP.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0.
  - All registered outputs are 0: mem_req_*, port_resp_valid, port_resp_rdata, protocol_err.
  - port_req_ready=0.
  - Any in-flight transaction is abandoned; no response is delivered after reset.
- FSM IDLE:
  - port_req_ready is combinational: the one-hot grant of the first asserted port_req_valid, searching rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - It is 0 when no port is valid, and 0 in every other state.
  - On the grant edge: latch owner index, write, addr and wdata into the mem_req_* registers; set mem_req_valid=1; go to ISSUE.
- FSM ISSUE:
  - Hold mem_req_valid and the payload stable until mem_req_valid&mem_req_ready.
  - On that edge, if write: clear mem_req_valid, set rr_ptr=(owner+1) mod NUM_PORTS, go to IDLE.
  - On that edge, if read: clear mem_req_valid, go to WAIT_RESP.
- FSM WAIT_RESP:
  - On mem_resp_valid: register port_resp_rdata=mem_resp_rdata and port_resp_valid=onehot(owner) for exactly one cycle, the cycle after mem_resp_valid.
  - On the same edge: set rr_ptr=owner+1 mod NUM_PORTS and go to IDLE.
- Latency:
  - A granted request reaches mem_req_valid 1 cycle after the grant edge.
  - A read response reaches the port 1 cycle after mem_resp_valid.
  - Minimum spacing between grants: 2 cycles for a write with mem_req_ready high.
- Simultaneous requests: only one grant per IDLE cycle. Non-granted ports must hold valid and payload until granted.
- Fairness: a continuously asserting port is granted at least once every NUM_PORTS transactions.
- Wrap-around: rr_ptr increments from NUM_PORTS-1 to 0.
- A port dropping valid before its grant is legal; the arbiter ignores it.
- Back-to-back: the transition into IDLE and the next grant happen on consecutive cycles; there is no bubble beyond the IDLE cycle.
- A mem_resp_valid in IDLE or ISSUE is ignored for routing and sets protocol_err; protocol_err clears only on reset.
- Write transactions never produce port_resp_valid.

Test Plan:
- Single read:
  - Stimulus: port2 reads addr 0x1040; mem_req_ready=1; mem_resp_valid 4 cycles later with data 0xAB...AB.
  - Required: mem_req_addr=0x1040, mem_req_write=0.
  - Required: port_resp_valid=4'b0100 for exactly 1 cycle with data 0xAB...AB; rr_ptr=3.
- All four ports request together with rr_ptr=0, all writes:
  - Required: grant order 0,1,2,3.
  - Required: four memory writes with the matching addr/wdata.
  - Required: no port_resp_valid.
- Fairness and wrap:
  - Stimulus: port3 then port0 hold continuous reads.
  - Required: grants alternate 3,0,3,0.
  - Required: rr_ptr wraps 3→0 correctly.
- Backpressure:
  - Stimulus: mem_req_ready held low for 5 cycles in ISSUE.
  - Required: mem_req_valid, addr and wdata are stable throughout.
  - Required: no new port_req_ready is asserted.
  - Required: the transfer completes on the first ready cycle.
- Spurious response:
  - Stimulus: mem_resp_valid pulsed in IDLE.
  - Required: no port_resp_valid; protocol_err=1 and it stays 1.
- Reset mid-read:
  - Stimulus: rst_n low during WAIT_RESP.
  - Required: all outputs are 0 immediately.
  - Required: a later mem_resp_valid is flagged by protocol_err, and no port receives data.
